// File: rtl/rv32v_uop_sequencer.sv
// rv32v_uop_sequencer: splits one decoded vector instruction into per-register uops
//   in_*      decoded instruction (valid/ready handshake, latched on accept)
//   uop_*     one uop per register of the LMUL group (valid/ready handshake)
//   flush     kills the current instruction; busy/done/illegal report status
//   Optional macro RV32V_UOP_VSTART_EN adds in_vstart and starts at element vstart.
module rv32v_uop_sequencer #(
  parameter int VLENB = 16,
  parameter int VL_W  = $clog2(VLENB*8+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_vd,
  input  logic [4:0]       in_vs1,
  input  logic [4:0]       in_vs2,
  input  logic [1:0]       in_sew,
  input  logic [1:0]       in_lmul,
  input  logic [VL_W-1:0]  in_vl,
`ifdef RV32V_UOP_VSTART_EN
  input  logic [VL_W-1:0]  in_vstart,
`endif
  input  logic             flush,
  output logic             uop_valid,
  input  logic             uop_ready,
  output logic [4:0]       uop_vd,
  output logic [4:0]       uop_vs1,
  output logic [4:0]       uop_vs2,
  output logic [2:0]       uop_idx,
  output logic [VL_W-1:0]  uop_elem_base,
  output logic [VLENB-1:0] uop_byte_en,
  output logic             uop_last,
  output logic             busy,
  output logic             done,
  output logic             illegal
);
  localparam int LB = $clog2(VLENB);
  typedef enum logic {IDLE, SEQ} state_t;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d, start_idx;
  logic [4:0] vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d, align_mask;
  logic [1:0] sew_q, sew_d;
  logic [VL_W-1:0] vl_q, vl_d, vst_q, vst_d, vstart_in, in_epr, in_vlmax, epr, elem_base, elem;
  logic done_q, done_d, illegal_q, illegal_d;
  logic seq, accept, bad, last;
`ifdef RV32V_UOP_VSTART_EN
  assign vstart_in = in_vstart;
`else
  assign vstart_in = '0;
`endif
  always_comb begin
    seq = state_q == SEQ;
    in_ready = ~seq & ~flush;
    accept = in_valid & in_ready;
    in_epr = VL_W'(VLENB >> in_sew);
    in_vlmax = in_epr << in_lmul;
    align_mask = 5'((1 << in_lmul) - 1);
    bad = (in_sew == 2'b11) | (in_vl > in_vlmax) | (|((in_vd | in_vs1 | in_vs2) & align_mask));
    // first register touched is the one holding element vstart
    start_idx = 3'(vstart_in >> (LB - in_sew));
    epr = VL_W'(VLENB >> sew_q);
    elem_base = VL_W'(idx_q) * epr;
    last = (elem_base + epr) >= vl_q;
    state_d = state_q;
    idx_d = idx_q;
    vd_d = vd_q;
    vs1_d = vs1_q;
    vs2_d = vs2_q;
    sew_d = sew_q;
    vl_d = vl_q;
    vst_d = vst_q;
    done_d = 1'b0;
    illegal_d = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else if (accept) begin
      vd_d = in_vd;
      vs1_d = in_vs1;
      vs2_d = in_vs2;
      sew_d = in_sew;
      vl_d = in_vl;
      vst_d = vstart_in;
      idx_d = start_idx;
      illegal_d = bad;
      done_d = ~bad & (vstart_in >= in_vl);
      state_d = (~bad & (vstart_in < in_vl)) ? SEQ : IDLE;
    end else if (seq & uop_ready) begin
      idx_d = idx_q + 3'd1;
      state_d = last ? IDLE : SEQ;
      done_d = last;
    end
    elem = '0;
    for (int b = 0; b < VLENB; b++) begin
      elem = elem_base + VL_W'(b >> sew_q);
      uop_byte_en[b] = seq & (elem >= vst_q) & (elem < vl_q);
    end
    uop_valid = seq;
    uop_vd = seq ? vd_q + {2'b0, idx_q} : '0;
    uop_vs1 = seq ? vs1_q + {2'b0, idx_q} : '0;
    uop_vs2 = seq ? vs2_q + {2'b0, idx_q} : '0;
    uop_idx = seq ? idx_q : '0;
    uop_elem_base = seq ? elem_base : '0;
    uop_last = seq & last;
    busy = seq;
    done = done_q;
    illegal = illegal_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      vd_q <= '0;
      vs1_q <= '0;
      vs2_q <= '0;
      sew_q <= '0;
      vl_q <= '0;
      vst_q <= '0;
      done_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      vd_q <= vd_d;
      vs1_q <= vs1_d;
      vs2_q <= vs2_d;
      sew_q <= sew_d;
      vl_q <= vl_d;
      vst_q <= vst_d;
      done_q <= done_d;
      illegal_q <= illegal_d;
    end
  end
endmodule
